calc_entry_ctrl: RTL and testbench

Keypad-side front end of the calculator: turns a stream of decoded key codes into the BCD operands, operator code and `exe` strobe that the arithmetic unit consumes. It captures the unit's BCD result and drives the 4-digit display word. It also supports chaining, where the last result becomes the next first operand.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/calc_entry_ctrl_if.sv | 23 ++
 rtl/bcd_digit_reg.sv | 50 +++++
 rtl/calc_entry_ctrl.sv | 159 +++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry front end: key codes,
// operator codes, the NaN result marker and the entry FSM encoding.
package calc_pkg;

    localparam logic [3:0]  KEY_EQ    = 4'd10;
    localparam logic [3:0]  KEY_CLR   = 4'd11;
    localparam logic [3:0]  OP_PLUS   = 4'd12;
    localparam logic [3:0]  OP_MINUS  = 4'd13;
    localparam logic [3:0]  OP_MULT   = 4'd14;
    localparam logic [3:0]  OP_DIV    = 4'd15;
    localparam logic [15:0] NAN       = 16'hFBAB;

    typedef enum logic [2:0] {
        S_NUM1   = 3'd0,
        S_OP     = 3'd1,
        S_NUM2   = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_RESULT = 3'd5
    } state_t;

    // Key codes 0..9 are decimal digits.
    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

    // Key codes 12..15 are the four operators.
    function automatic logic is_op(input logic [3:0] k);
        return (k >= OP_PLUS);
    endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Keypad / arithmetic-unit side bus of the calculator entry controller.
// master: keypad and arithmetic unit side; slave: the entry controller.
interface calc_entry_ctrl_if;
    logic [3:0]  key;
    logic        key_valid;
    logic [15:0] res;
    logic [15:0] num1;
    logic [15:0] num2;
    logic [3:0]  op;
    logic        exe;
    logic [15:0] disp;
    logic        err;

    modport master (
        output key, key_valid, res,
        input  num1, num2, op, exe, disp, err
    );

    modport slave (
        input  key, key_valid, res,
        output num1, num2, op, exe, disp, err
    );
endinterface

// File: rtl/bcd_digit_reg.sv
// BCD operand register: digits shift in from the right, a single digit or a
// whole word can be loaded, and 'full' flags a non-zero top digit so the
// owner can refuse further digits.
module bcd_digit_reg #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load_digit,
    input  logic                  shift_digit,
    input  logic                  load_word,
    input  logic [3:0]            digit,
    input  logic [4*DIGITS-1:0]   word,
    output logic [4*DIGITS-1:0]   val,
    output logic                  full
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    // Next operand value; clear wins over word load, word over digit load.
    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = '0;
        end else if (load_word) begin
            val_d = word;
        end else if (load_digit) begin
            val_d = {{(W-4){1'b0}}, digit};
        end else if (shift_digit) begin
            val_d = {val_q[W-5:0], digit};
        end else begin
            val_d = val_q;
        end
    end

    // Operand storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign full = (val_q[W-1:W-4] != 4'd0);
    assign val  = val_q;
endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: collects BCD operands and an operator from
// key codes, strobes the arithmetic unit, captures its result for display
// and supports chaining the result into the next calculation.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    calc_entry_ctrl_if.slave   bus
);
    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] acc_q, acc_d;

    logic        n1_clr, n1_ld_dig, n1_shift, n1_ld_word, n1_full;
    logic        n2_clr, n2_ld_dig, n2_shift, n2_full;
    logic [15:0] num1_s, num2_s;
    logic [15:0] disp_s;
    logic        kv_dig_s, kv_op_s;

    assign kv_dig_s = bus.key_valid && is_digit(bus.key);
    assign kv_op_s  = bus.key_valid && is_op(bus.key);

    bcd_digit_reg #(.DIGITS(DIGITS)) u_num1 (
        .clk         (clk),
        .rst         (rst),
        .clr         (n1_clr),
        .load_digit  (n1_ld_dig),
        .shift_digit (n1_shift),
        .load_word   (n1_ld_word),
        .digit       (bus.key),
        .word        (acc_q),
        .val         (num1_s),
        .full        (n1_full)
    );

    bcd_digit_reg #(.DIGITS(DIGITS)) u_num2 (
        .clk         (clk),
        .rst         (rst),
        .clr         (n2_clr),
        .load_digit  (n2_ld_dig),
        .shift_digit (n2_shift),
        .load_word   (1'b0),
        .digit       (bus.key),
        .word        (16'h0000),
        .val         (num2_s),
        .full        (n2_full)
    );

    // Next-state, operator, result capture and operand control decode.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        n1_clr     = 1'b0;
        n1_ld_dig  = 1'b0;
        n1_shift   = 1'b0;
        n1_ld_word = 1'b0;
        n2_clr     = 1'b0;
        n2_ld_dig  = 1'b0;
        n2_shift   = 1'b0;
        if (bus.key_valid && (bus.key == KEY_CLR)) begin
            n1_clr  = 1'b1;
            n2_clr  = 1'b1;
            acc_d   = 16'h0000;
            op_d    = OP_PLUS;
            state_d = S_NUM1;
        end else begin
            case (state_q)
                S_NUM1: begin
                    if (kv_dig_s) begin
                        n1_shift = !n1_full;
                    end else if (kv_op_s) begin
                        op_d    = bus.key;
                        state_d = S_OP;
                    end else begin
                        state_d = S_NUM1;
                    end
                end
                S_OP: begin
                    if (kv_op_s) begin
                        op_d = bus.key;
                    end else if (kv_dig_s) begin
                        n2_ld_dig = 1'b1;
                        state_d   = S_NUM2;
                    end else begin
                        state_d = S_OP;
                    end
                end
                S_NUM2: begin
                    if (kv_dig_s) begin
                        n2_shift = !n2_full;
                    end else if (bus.key_valid && (bus.key == KEY_EQ)) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_NUM2;
                    end
                end
                S_EXEC: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    acc_d   = bus.res;
                    state_d = S_RESULT;
                end
                S_RESULT: begin
                    if (kv_dig_s) begin
                        n1_ld_dig = 1'b1;
                        n2_clr    = 1'b1;
                        state_d   = S_NUM1;
                    end else if (kv_op_s && (acc_q != NAN)) begin
                        n1_ld_word = 1'b1;
                        n2_clr     = 1'b1;
                        op_d       = bus.key;
                        state_d    = S_OP;
                    end else begin
                        state_d = S_RESULT;
                    end
                end
                default: begin
                    state_d = S_NUM1;
                end
            endcase
        end
    end

    // State, operator and captured-result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_NUM1;
            op_q    <= OP_PLUS;
            acc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
        end
    end

    // Display source follows the phase of entry.
    always_comb begin
        disp_s = num1_s;
        case (state_q)
            S_NUM1, S_OP:          disp_s = num1_s;
            S_NUM2, S_EXEC, S_WAIT: disp_s = num2_s;
            S_RESULT:              disp_s = acc_q;
            default:               disp_s = num1_s;
        endcase
    end

    assign bus.num1 = num1_s;
    assign bus.num2 = num2_s;
    assign bus.op   = op_q;
    assign bus.exe  = (state_q == S_EXEC);
    assign bus.disp = disp_s;
    assign bus.err  = (state_q == S_RESULT) && (acc_q == NAN);
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl: a table of key presses with expected
// outputs, followed by hand-written multi-cycle sequences.
module tb_calc_entry_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    calc_entry_ctrl_if bus ();

    calc_entry_ctrl #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] n1;
        logic [15:0] n2;
        logic [3:0]  op;
        logic [15:0] disp;
        logic        exe;
        logic        err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] n1, input logic [15:0] n2,
                           input logic [3:0] op, input logic [15:0] disp,
                           input logic exe, input logic err);
        chk({tag, ".num1"}, bus.num1, n1);
        chk({tag, ".num2"}, bus.num2, n2);
        chk({tag, ".op"},   {12'h000, bus.op}, {12'h000, op});
        chk({tag, ".disp"}, bus.disp, disp);
        chk({tag, ".exe"},  {15'h0000, bus.exe}, {15'h0000, exe});
        chk({tag, ".err"},  {15'h0000, bus.err}, {15'h0000, err});
    endtask

    // One key strobe; returns 1 ns after the sampling edge.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key       = k;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Equals followed by the exe / wait / capture timeline.
    task automatic do_equals(input string tag, input logic [15:0] n2, input logic [15:0] result,
                             input logic err_exp);
        logic [15:0] n1_snap;
        logic [3:0]  op_snap;
        n1_snap = bus.num1;
        op_snap = bus.op;
        bus.res = result;
        press(4'd10);
        chk({tag, ".exe_hi"},  {15'h0000, bus.exe}, 16'h0001);
        chk({tag, ".disp_ex"}, bus.disp, n2);
        chk({tag, ".n1_ex"},   bus.num1, n1_snap);
        chk({tag, ".op_ex"},   {12'h000, bus.op}, {12'h000, op_snap});
        step();
        chk({tag, ".exe_lo"},  {15'h0000, bus.exe}, 16'h0000);
        chk({tag, ".disp_wt"}, bus.disp, n2);
        step();
        chk({tag, ".disp_res"}, bus.disp, result);
        chk({tag, ".err_res"},  {15'h0000, bus.err}, {15'h0000, err_exp});
        chk({tag, ".exe_res"},  {15'h0000, bus.exe}, 16'h0000);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.key       = 4'd0;
        bus.key_valid = 1'b0;
        bus.res       = 16'h0000;

        //            key    num1      num2      op     disp      exe   err
        vecs[0]  = '{4'd1,  16'h0001, 16'h0000, 4'd12, 16'h0001, 1'b0, 1'b0};
        vecs[1]  = '{4'd2,  16'h0012, 16'h0000, 4'd12, 16'h0012, 1'b0, 1'b0};
        vecs[2]  = '{4'd3,  16'h0123, 16'h0000, 4'd12, 16'h0123, 1'b0, 1'b0};
        vecs[3]  = '{4'd4,  16'h1234, 16'h0000, 4'd12, 16'h1234, 1'b0, 1'b0};
        vecs[4]  = '{4'd5,  16'h1234, 16'h0000, 4'd12, 16'h1234, 1'b0, 1'b0};
        vecs[5]  = '{4'd11, 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0};
        vecs[6]  = '{4'd1,  16'h0001, 16'h0000, 4'd12, 16'h0001, 1'b0, 1'b0};
        vecs[7]  = '{4'd2,  16'h0012, 16'h0000, 4'd12, 16'h0012, 1'b0, 1'b0};
        vecs[8]  = '{4'd10, 16'h0012, 16'h0000, 4'd12, 16'h0012, 1'b0, 1'b0};
        vecs[9]  = '{4'd13, 16'h0012, 16'h0000, 4'd13, 16'h0012, 1'b0, 1'b0};
        vecs[10] = '{4'd12, 16'h0012, 16'h0000, 4'd12, 16'h0012, 1'b0, 1'b0};
        vecs[11] = '{4'd3,  16'h0012, 16'h0003, 4'd12, 16'h0003, 1'b0, 1'b0};
        vecs[12] = '{4'd4,  16'h0012, 16'h0034, 4'd12, 16'h0034, 1'b0, 1'b0};
        vecs[13] = '{4'd14, 16'h0012, 16'h0034, 4'd12, 16'h0034, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Digit entry, fifth-digit drop, clear, operator replace, entry of 12+34.
        for (int i = 0; i < 14; i++) begin
            press(vecs[i].key);
            chk_all($sformatf("vec%0d", i), vecs[i].n1, vecs[i].n2, vecs[i].op,
                    vecs[i].disp, vecs[i].exe, vecs[i].err);
        end
        do_equals("add", 16'h0034, 16'h0046, 1'b0);
        step();
        chk("add.hold", bus.disp, 16'h0046);

        // Division by zero yields NaN; an operator is then ignored.
        press(4'd8);
        chk_all("nan.d8", 16'h0008, 16'h0000, 4'd12, 16'h0008, 1'b0, 1'b0);
        press(4'd15);
        press(4'd0);
        chk_all("nan.d0", 16'h0008, 16'h0000, 4'd15, 16'h0000, 1'b0, 1'b0);
        do_equals("div", 16'h0000, 16'hFBAB, 1'b1);
        press(4'd12);
        chk_all("nan.plus", 16'h0008, 16'h0000, 4'd15, 16'hFBAB, 1'b0, 1'b1);
        press(4'd7);
        chk_all("nan.d7", 16'h0007, 16'h0000, 4'd15, 16'h0007, 1'b0, 1'b0);

        // Chaining: 9*9=81, then -1 = 80.
        press(4'd11);
        press(4'd9);
        press(4'd14);
        press(4'd9);
        do_equals("mul", 16'h0009, 16'h0081, 1'b0);
        press(4'd13);
        chk_all("chain.op", 16'h0081, 16'h0000, 4'd13, 16'h0081, 1'b0, 1'b0);
        press(4'd1);
        chk_all("chain.d1", 16'h0081, 16'h0001, 4'd13, 16'h0001, 1'b0, 1'b0);
        do_equals("sub", 16'h0001, 16'h0080, 1'b0);

        // Clear while exe is high: nothing is captured.
        press(4'd11);
        press(4'd5);
        press(4'd12);
        press(4'd3);
        bus.res = 16'h0008;
        press(4'd10);
        chk("clrx.exe_hi", {15'h0000, bus.exe}, 16'h0001);
        press(4'd11);
        chk_all("clrx.next", 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0);
        repeat (3) step();
        chk_all("clrx.later", 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of second-operand entry.
        press(4'd4);
        press(4'd12);
        press(4'd4);
        press(4'd2);
        chk_all("arst.pre", 16'h0004, 16'h0042, 4'd12, 16'h0042, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst.now", 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        press(4'd6);
        chk_all("arst.resume", 16'h0006, 16'h0000, 4'd12, 16'h0006, 1'b0, 1'b0);

        // Asynchronous reset while exe is high drops exe immediately.
        press(4'd12);
        press(4'd1);
        bus.res = 16'h0007;
        press(4'd10);
        chk("arstx.exe_hi", {15'h0000, bus.exe}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        chk_all("arstx.now", 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step();
        chk_all("arstx.later", 16'h0000, 16'h0000, 4'd12, 16'h0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
